// File: rtl/sfu_pkg.sv
// Shared types and defaults for the SFU accumulation sequencer.
package sfu_pkg;

  localparam int unsigned COL_DEF   = 8;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned KIJ_DEF   = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sfu_state_e;

  // Clamp a negative psum to zero; only the sign bit is inspected.
  function automatic logic [DW_DEF-1:0] relu(input logic signed [DW_DEF-1:0] x);
    return x[DW_DEF-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/sfu_drain_stage.sv
// Read gating, optional ReLU and valid/ready output register for the COL lanes.
module sfu_drain_stage
  import sfu_pkg::*;
#(
  parameter int unsigned COL = COL_DEF,
  parameter int unsigned DW  = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en_i,
  input  logic              relu_en_i,
  input  logic [COL*DW-1:0] rd_data_i,
  input  logic              out_ready_i,
  output logic              fifo_rd_o,
  output logic [COL*DW-1:0] out_data_o,
  output logic              out_valid_o
);

  logic [COL*DW-1:0] data_q;
  logic              valid_q;
  logic [COL*DW-1:0] lanes_c;

  // Pop only when the output register is empty or being emptied this cycle.
  assign fifo_rd_o = rd_en_i & (~valid_q | out_ready_i);

  // Per-lane ReLU on the tile output.
  for (genvar c = 0; c < COL; c++) begin : g_lane
    logic [DW-1:0] lane_in;
    assign lane_in = rd_data_i[c*DW +: DW];
    if (DW == DW_DEF) begin : g_fn
      assign lanes_c[c*DW +: DW] = relu_en_i ? DW'(relu(DW_DEF'(lane_in))) : lane_in;
    end else begin : g_msb
      assign lanes_c[c*DW +: DW] = (relu_en_i && lane_in[DW-1]) ? '0 : lane_in;
    end
  end

  // Output register: load on pop, hold while stalled, drop valid once accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fifo_rd_o) begin
      data_q  <= lanes_c;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/sfu_acc_ctrl.sv
// Sequencer for one row of accumulating output-FIFO tiles: clear, KIJ passes, drain.
module sfu_acc_ctrl
  import sfu_pkg::*;
#(
  parameter int unsigned COL   = COL_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned KIJ   = KIJ_DEF,
  parameter int unsigned KW    = $clog2(KIJ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_relu,
  input  logic [COL-1:0]    col_valid,
  input  logic [COL*DW-1:0] fifo_rd_data,
  output logic [COL-1:0]    fifo_wr,
  output logic              fifo_rd,
  output logic              fifo_clr,
  output logic [KW-1:0]     kij_cnt,
  output logic [COL*DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  sfu_state_e    state_q, state_d;
  logic [KW-1:0] kij_q, kij_d;
  logic [CW-1:0] wcnt_q [COL];
  logic [CW-1:0] wcnt_d [COL];
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          relu_q, relu_d;
  logic          err_q, err_d;
  logic [COL-1:0] wr_c;
  logic          all_full_c;
  logic          rd_en_c;
  logic          fifo_rd_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Counters and run configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      kij_q  <= '0;
      rcnt_q <= '0;
      relu_q <= 1'b0;
      err_q  <= 1'b0;
      for (int c = 0; c < COL; c++) wcnt_q[c] <= '0;
    end else begin
      kij_q  <= kij_d;
      rcnt_q <= rcnt_d;
      relu_q <= relu_d;
      err_q  <= err_d;
      for (int c = 0; c < COL; c++) wcnt_q[c] <= wcnt_d[c];
    end
  end

  // A pass is complete once every column has taken DEPTH psums.
  always_comb begin
    all_full_c = 1'b1;
    for (int c = 0; c < COL; c++) begin
      if (wcnt_q[c] != CW'(DEPTH)) all_full_c = 1'b0;
    end
  end

  // Next-state and write sequencing.
  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    rcnt_d  = rcnt_q;
    relu_d  = relu_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    wr_c    = '0;
    rd_en_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          relu_d  = cfg_relu;
          err_d   = 1'b0;
          kij_d   = '0;
          rcnt_d  = '0;
          for (int c = 0; c < COL; c++) wcnt_d[c] = '0;
        end
      end

      CLEAR: begin
        state_d = ACCUM;
      end

      ACCUM: begin
        for (int c = 0; c < COL; c++) begin
          if (col_valid[c]) begin
            if (wcnt_q[c] < CW'(DEPTH)) begin
              wr_c[c]   = 1'b1;
              wcnt_d[c] = wcnt_q[c] + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (all_full_c) begin
          if (kij_q == KW'(KIJ - 1)) begin
            state_d = DRAIN;
            rcnt_d  = '0;
          end else begin
            kij_d = kij_q + KW'(1);
            for (int c = 0; c < COL; c++) wcnt_d[c] = '0;
          end
        end
      end

      DRAIN: begin
        rd_en_c = (rcnt_q < CW'(DEPTH));
        if (fifo_rd_c) rcnt_d = rcnt_q + CW'(1);
        if ((rcnt_q == CW'(DEPTH)) && (!out_valid || out_ready)) state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sfu_drain_stage #(
    .COL (COL),
    .DW  (DW)
  ) u_drain (
    .clk         (clk),
    .reset       (reset),
    .rd_en_i     (rd_en_c),
    .relu_en_i   (relu_q),
    .rd_data_i   (fifo_rd_data),
    .out_ready_i (out_ready),
    .fifo_rd_o   (fifo_rd_c),
    .out_data_o  (out_data),
    .out_valid_o (out_valid)
  );

  assign fifo_wr     = wr_c;
  assign fifo_rd     = fifo_rd_c;
  assign fifo_clr    = (state_q == CLEAR);
  assign kij_cnt     = kij_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_sfu_acc_ctrl.sv
// Directed bench for sfu_acc_ctrl with a behavioural accumulating-tile model.
module tb_sfu_acc_ctrl;

  localparam int COL   = 8;
  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int KIJ   = 9;
  localparam int KW    = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              cfg_relu;
  logic [COL-1:0]    col_valid;
  logic [COL*DW-1:0] fifo_rd_data;
  logic [COL-1:0]    fifo_wr;
  logic              fifo_rd;
  logic              fifo_clr;
  logic [KW-1:0]     kij_cnt;
  logic [COL*DW-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err_overrun;

  int n_vec = 0;
  int n_err = 0;

  sfu_acc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_relu     (cfg_relu),
    .col_valid    (col_valid),
    .fifo_rd_data (fifo_rd_data),
    .fifo_wr      (fifo_wr),
    .fifo_rd      (fifo_rd),
    .fifo_clr     (fifo_clr),
    .kij_cnt      (kij_cnt),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err_overrun  (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile model: cleared by reset or fifo_clr, adds each written psum, show-ahead read.
  logic signed [DW-1:0] acc [COL][DEPTH];
  logic [3:0]           widx [COL];
  logic [3:0]           ridx;
  logic signed [DW-1:0] psum_in [COL];

  always @(posedge clk) begin
    if (reset || fifo_clr) begin
      for (int c = 0; c < COL; c++) begin
        for (int p = 0; p < DEPTH; p++) acc[c][p] <= '0;
        widx[c] <= '0;
      end
      ridx <= '0;
    end else begin
      for (int c = 0; c < COL; c++) begin
        if (fifo_wr[c]) begin
          acc[c][widx[c]] <= acc[c][widx[c]] + psum_in[c];
          widx[c]         <= widx[c] + 4'd1;
        end
      end
      if (fifo_rd) ridx <= ridx + 4'd1;
    end
  end

  always_comb begin
    fifo_rd_data = '0;
    for (int c = 0; c < COL; c++) fifo_rd_data[c*DW +: DW] = acc[c][ridx];
  end

  // Event monitor, sampled on the falling edge.
  int                n_wr [COL] = '{default: 0};
  int                n_rd = 0;
  int                n_clr = 0;
  int                n_done = 0;
  int                kij_steps = 0;
  int                kij_bad = 0;
  int                stall_bad = 0;
  logic [KW-1:0]     kij_prev = '0;
  logic              hold_pend = 1'b0;
  logic [COL*DW-1:0] held = '0;
  logic [COL*DW-1:0] beats [$];

  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < COL; c++) if (fifo_wr[c]) n_wr[c]++;
      if (fifo_rd)  n_rd++;
      if (fifo_clr) n_clr++;
      if (done)     n_done++;
      if (kij_cnt != kij_prev) begin
        if (kij_cnt == kij_prev + 4'd1) kij_steps++;
        else if (kij_cnt != '0)         kij_bad++;
      end
      if (kij_cnt > KW'(KIJ - 1)) kij_bad++;
      if (out_valid && out_ready) beats.push_back(out_data);
      if (hold_pend && (!out_valid || out_data != held)) stall_bad++;
    end
    kij_prev  = kij_cnt;
    hold_pend = !reset && out_valid && !out_ready;
    held      = out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and step into the first ACCUM cycle.
  task automatic start_run(input logic relu);
    start    = 1'b1;
    cfg_relu = relu;
    tick();
    start    = 1'b0;
    cfg_relu = 1'b0;
    n_vec++;
    if (fifo_clr !== 1'b1 || busy !== 1'b1 || err_overrun !== 1'b0 || kij_cnt !== '0) begin
      n_err++;
      $display("FAIL clear_cycle: clr=%b busy=%b err=%b kij=%0d, want 1 1 0 0",
               fifo_clr, busy, err_overrun, kij_cnt);
    end
    tick();
  endtask

  // One kernel pass; column c delayed by c*skew, column 0 gets extra0 surplus valids.
  task automatic run_pass(input int k, input int skew, input int extra0, input logic neg);
    int span;
    int w;
    int want_w;
    span = DEPTH + (COL - 1) * skew;
    if (DEPTH + extra0 > span) span = DEPTH + extra0;
    n_vec++;
    if (kij_cnt !== KW'(k)) begin
      n_err++;
      $display("FAIL pass_start_kij: got %0d want %0d", kij_cnt, k);
    end
    for (int t = 0; t < span; t++) begin
      for (int c = 0; c < COL; c++) begin
        int p;
        int lim;
        p   = t - c * skew;
        lim = DEPTH + ((c == 0) ? extra0 : 0);
        col_valid[c] = (p >= 0) && (p < lim);
        psum_in[c]   = neg ? DW'(-5) : DW'(p + 1);
      end
      if (t == span - 1) begin
        n_vec++;
        if (kij_cnt !== KW'(k)) begin
          n_err++;
          $display("FAIL kij_hold_last_write: got %0d want %0d", kij_cnt, k);
        end
      end
      tick();
    end
    col_valid = '0;
    if (k < KIJ - 1) begin
      want_w = (extra0 > 0 && skew == 0) ? 0 : 1;
      w = 0;
      while (kij_cnt !== KW'(k + 1) && w < 40) begin
        tick();
        w++;
      end
      n_vec++;
      if (w != want_w) begin
        n_err++;
        $display("FAIL kij_advance_delay: got %0d cycles want %0d", w, want_w);
      end
    end
  endtask

  // Wait for the done pulse, optionally toggling out_ready every cycle.
  task automatic drain_wait(input logic alt, input int done_base);
    int w;
    w = 0;
    while (n_done == done_base && w < 400) begin
      if (alt) out_ready = ~out_ready;
      tick();
      w++;
    end
    out_ready = 1'b1;
    n_vec++;
    if (n_done != done_base + 1) begin
      n_err++;
      $display("FAIL done_pulse: got %0d pulses want 1", n_done - done_base);
    end
  endtask

  task automatic do_run(input logic relu, input int skew, input logic neg, input logic alt);
    int db;
    db = n_done;
    start_run(relu);
    for (int k = 0; k < KIJ; k++) run_pass(k, skew, 0, neg);
    drain_wait(alt, db);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b1;
    col_valid = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || fifo_wr !== '0 || err_overrun !== 1'b0 ||
          fifo_clr !== 1'b0 || kij_cnt !== '0) begin
        n_err++;
        $display("FAIL reset_hold: busy=%b ov=%b wr=%h err=%b clr=%b kij=%0d, want all 0",
                 busy, out_valid, fifo_wr, err_overrun, fifo_clr, kij_cnt);
      end
    end
    reset     = 1'b0;
    start     = 1'b0;
    col_valid = '0;
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_full_run();
    int wr0 [COL];
    int rd0, clr0, ks0, kb0, bq;
    logic [COL*DW-1:0] exp_v, got_v;
    for (int c = 0; c < COL; c++) wr0[c] = n_wr[c];
    rd0 = n_rd; clr0 = n_clr; ks0 = kij_steps; kb0 = kij_bad; bq = beats.size();
    do_run(1'b0, 0, 1'b0, 1'b0);
    n_vec++;
    if (n_clr - clr0 != 1) begin
      n_err++; $display("FAIL full_clr_pulses: got %0d want 1", n_clr - clr0);
    end
    for (int c = 0; c < COL; c++) begin
      n_vec++;
      if (n_wr[c] - wr0[c] != KIJ * DEPTH) begin
        n_err++; $display("FAIL full_wr_col%0d: got %0d want %0d", c, n_wr[c] - wr0[c], KIJ * DEPTH);
      end
    end
    n_vec++;
    if (n_rd - rd0 != DEPTH) begin
      n_err++; $display("FAIL full_rd_count: got %0d want %0d", n_rd - rd0, DEPTH);
    end
    n_vec++;
    if (kij_steps - ks0 != KIJ - 1 || kij_bad != kb0) begin
      n_err++; $display("FAIL full_kij_steps: got %0d steps %0d bad want %0d 0",
                        kij_steps - ks0, kij_bad - kb0, KIJ - 1);
    end
    n_vec++;
    if (beats.size() - bq != DEPTH) begin
      n_err++; $display("FAIL full_beat_count: got %0d want %0d", beats.size() - bq, DEPTH);
    end
    for (int p = 0; p < DEPTH; p++) begin
      for (int c = 0; c < COL; c++) exp_v[c*DW +: DW] = DW'(KIJ * (p + 1));
      got_v = (bq + p < beats.size()) ? beats[bq + p] : 'x;
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL full_beat%0d: got %h want %h", p, got_v, exp_v);
      end
    end
    n_vec++;
    if (err_overrun !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL full_end_state: err=%b busy=%b ov=%b want 0 0 0",
                        err_overrun, busy, out_valid);
    end
  endtask

  task automatic test_relu();
    int bq;
    logic [COL*DW-1:0] exp_v, got_v;
    for (int m = 0; m < 2; m++) begin
      bq = beats.size();
      do_run((m == 0), 0, 1'b1, 1'b0);
      for (int c = 0; c < COL; c++) exp_v[c*DW +: DW] = (m == 0) ? DW'(0) : 16'hFFD3;
      n_vec++;
      if (beats.size() - bq != DEPTH) begin
        n_err++; $display("FAIL relu%0d_beat_count: got %0d want %0d", m, beats.size() - bq, DEPTH);
      end
      for (int p = 0; p < DEPTH; p++) begin
        got_v = (bq + p < beats.size()) ? beats[bq + p] : 'x;
        n_vec++;
        if (got_v !== exp_v) begin
          n_err++; $display("FAIL relu%0d_beat%0d: got %h want %h", m, p, got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_skew();
    int wr0 [COL];
    int bq;
    logic [COL*DW-1:0] exp_v, got_v;
    for (int c = 0; c < COL; c++) wr0[c] = n_wr[c];
    bq = beats.size();
    do_run(1'b0, 1, 1'b0, 1'b0);
    n_vec++;
    if (err_overrun !== 1'b0) begin
      n_err++; $display("FAIL skew_overrun: got %b want 0", err_overrun);
    end
    for (int c = 0; c < COL; c++) begin
      n_vec++;
      if (n_wr[c] - wr0[c] != KIJ * DEPTH) begin
        n_err++; $display("FAIL skew_wr_col%0d: got %0d want %0d", c, n_wr[c] - wr0[c], KIJ * DEPTH);
      end
    end
    for (int p = 0; p < DEPTH; p++) begin
      for (int c = 0; c < COL; c++) exp_v[c*DW +: DW] = DW'(KIJ * (p + 1));
      got_v = (bq + p < beats.size()) ? beats[bq + p] : 'x;
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL skew_beat%0d: got %h want %h", p, got_v, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    int rd0, sb0, bq;
    logic [COL*DW-1:0] exp_v, got_v;
    rd0 = n_rd; sb0 = stall_bad; bq = beats.size();
    do_run(1'b0, 0, 1'b0, 1'b1);
    n_vec++;
    if (n_rd - rd0 != DEPTH) begin
      n_err++; $display("FAIL bp_rd_count: got %0d want %0d", n_rd - rd0, DEPTH);
    end
    n_vec++;
    if (stall_bad != sb0) begin
      n_err++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_bad - sb0);
    end
    n_vec++;
    if (beats.size() - bq != DEPTH) begin
      n_err++; $display("FAIL bp_beat_count: got %0d want %0d", beats.size() - bq, DEPTH);
    end
    for (int p = 0; p < DEPTH; p++) begin
      for (int c = 0; c < COL; c++) exp_v[c*DW +: DW] = DW'(KIJ * (p + 1));
      got_v = (bq + p < beats.size()) ? beats[bq + p] : 'x;
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL bp_beat%0d: got %h want %h", p, got_v, exp_v);
      end
    end
  endtask

  task automatic test_overrun_abort();
    int wr0 [COL];
    int db;
    int w;
    for (int c = 0; c < COL; c++) wr0[c] = n_wr[c];
    db = n_done;
    start_run(1'b0);
    run_pass(0, 0, 1, 1'b0);
    n_vec++;
    if (err_overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_flag: got %b want 1", err_overrun);
    end
    n_vec++;
    if (n_wr[0] - wr0[0] != DEPTH || n_wr[1] - wr0[1] != DEPTH) begin
      n_err++; $display("FAIL ovr_wr_count: col0 %0d col1 %0d want %0d", n_wr[0] - wr0[0],
                        n_wr[1] - wr0[1], DEPTH);
    end
    for (int k = 1; k < KIJ; k++) run_pass(k, 0, 0, 1'b0);
    drain_wait(1'b0, db);
    n_vec++;
    if (err_overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_sticky: got %b want 1", err_overrun);
    end
    // New run clears the flag; abort it with reset while the output is stalled.
    start_run(1'b0);
    for (int k = 0; k < KIJ; k++) run_pass(k, 0, 0, 1'b0);
    out_ready = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_vec++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || fifo_rd !== 1'b0 || kij_cnt !== KW'(KIJ - 1)) begin
      n_err++; $display("FAIL abort_pre_stall: ov=%b busy=%b rd=%b kij=%0d want 1 1 0 %0d",
                        out_valid, busy, fifo_rd, kij_cnt, KIJ - 1);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || kij_cnt !== '0 || err_overrun !== 1'b0) begin
      n_err++; $display("FAIL abort_reset: busy=%b ov=%b kij=%0d err=%b want 0 0 0 0",
                        busy, out_valid, kij_cnt, err_overrun);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || fifo_rd !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: busy=%b ov=%b rd=%b want 0 0 0", busy, out_valid, fifo_rd);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cfg_relu  = 1'b0;
    col_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < COL; c++) psum_in[c] = '0;
    test_reset();
    test_full_run();
    test_relu();
    test_skew();
    test_backpressure();
    test_overrun_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfu_acc_ctrl.md
Name: sfu_acc_ctrl

Overview:
- Sequencer for one row of COL accumulating output-FIFO tiles in the SFU.
- Clears the tiles, then runs KIJ kernel passes, each writing exactly DEPTH psums per column. Drives the tile kij counter so the tiles accumulate from pass 1 onward.
- Drains the accumulated sums through an optional ReLU into a valid/ready output register.

Parameters:
- COL, 8, number of FIFO tiles/columns controlled.
- DEPTH, 16, psums per column per pass; equals the tile FIFO depth.
- DW, 16, psum width (signed).
- KIJ, 9, kernel passes per tile; must be >1.
- KW, $clog2(KIJ), kij counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a tile run; honoured only in IDLE.
- cfg_relu  in  1  sampled at start; 1 = clamp negative outputs to 0.
- col_valid  in  COL  per-column psum valid from the array.
- fifo_rd_data  in  COL*DW  tile data_out, column c at [c*DW +: DW].
- fifo_wr  out  COL  per-column tile write strobe.
- fifo_rd  out  1  common read strobe to all tiles.
- fifo_clr  out  1  one-cycle pulse, ORed into the tile reset.
- kij_cnt  out  KW  current pass index, drives the tile counter port.
- out_data  out  COL*DW  registered drained sums.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at run end.
- err_overrun  out  1  sticky: a col_valid was dropped; cleared on start.

Behaviour:
- Reset: state IDLE. All counters 0. relu_q, fifo_wr, fifo_rd, fifo_clr, kij_cnt, out_data, out_valid, busy, done and err_overrun are all 0. Reset mid-run aborts; the tiles share reset.
- IDLE:
  - start=1 -> CLEAR; latch cfg_relu into relu_q; clear err_overrun.
  - start in any other state is ignored.
- CLEAR: one cycle with fifo_clr=1, fifo_wr=0, kij_cnt=0 -> ACCUM.
- ACCUM:
  - Per-column write counter wcnt[c] (0..DEPTH).
  - fifo_wr[c] = col_valid[c] & (wcnt[c]<DEPTH); wcnt[c] increments on each write.
  - col_valid[c] with wcnt[c]==DEPTH is dropped, fifo_wr[c]=0, and err_overrun is set.
  - Pass end is the cycle where all wcnt==DEPTH:
    - kij_cnt<KIJ-1: next cycle kij_cnt+1 and all wcnt cleared.
    - kij_cnt==KIJ-1: -> DRAIN, rcnt=0.
  - Upstream guarantees at least one idle cycle between passes. Columns may be skewed arbitrarily within a pass.
- DRAIN:
  - fifo_rd = (rcnt<DEPTH) & (~out_valid | out_ready).
  - On fifo_rd: rcnt+1, and out_data loads fifo_rd_data per column, with relu_q ? (x<0 ? 0 : x) : x.
  - out_valid is set on a load. It is cleared when out_ready=1 and no load occurs that cycle.
  - Latency: out_data is valid the cycle after fifo_rd.
  - While out_valid & ~out_ready, out_data is held stable and fifo_rd=0.
  - When rcnt==DEPTH and out_valid==0 (or last beat accepted) -> DONE.
- DONE: done=1 for one cycle -> IDLE. The next start is allowed in the following cycle.
- Widths and wrap:
  - kij_cnt never exceeds KIJ-1.
  - No arithmetic on data other than the sign test; ReLU is a signed compare of the MSB.
  - Sum overflow is the tile's responsibility.
- col_valid outside ACCUM is ignored: no write and no error.

Decomposition:
- Shared package sfu_pkg:
  - state enum {IDLE, CLEAR, ACCUM, DRAIN, DONE}.
  - Defaults for COL/DEPTH/DW/KIJ.
  - relu function (signed DW in -> DW out).
- One natural sub-module: sfu_drain_stage, the ReLU + valid/ready output register for the COL lanes (fifo_rd gating and out_data/out_valid). Write sequencing stays in the top.

Test Plan:
- Reset: hold reset 3 cycles with start=1 -> busy=0, out_valid=0, fifo_wr=0, err_overrun=0; no state change until reset drops.
- Full run, defaults: tile model gives psum p+1 for pixel p on every pass.
  - Each column sees 16 valids per pass with a 1-cycle gap.
  - Expect fifo_clr pulse once, kij_cnt stepping 0..8, 144 fifo_wr per column, 16 fifo_rd.
  - out_data lane values 9,18,...,144; done pulse once.
- ReLU: every psum -5. cfg_relu=1 -> all outputs 0; cfg_relu=0 -> all outputs -45 (0xFFD3).
- Skew: column c's valids delayed by c cycles. kij_cnt advances only after column 7's 16th write; no overrun.
- Backpressure: out_ready alternating 1,0 -> exactly 16 fifo_rd, no beat lost or duplicated, out_data stable across stalls.
- Overrun/abort: 17 valids on column 0 in pass 0 -> err_overrun=1 and 16 fifo_wr. Then reset mid-DRAIN -> next cycle busy=0, out_valid=0, kij_cnt=0.
